// File: rtl/ahb_uart_tx_if.sv
// AHB-Lite slave port bundle for the UART transmitter.
// Master drives the address/control/write data; slave returns read data and response.
interface ahb_uart_tx_if;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hwrite;
   logic        hsel;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hready;
   logic        hresp;

   modport master (
      output haddr, hwdata, hwrite, hsel, htrans, hsize,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  haddr, hwdata, hwrite, hsel, htrans, hsize,
      output hrdata, hready, hresp
   );
endinterface

// File: rtl/ahb_uart_tx.sv
// AHB-Lite UART transmitter: TX FIFO, baud divisor, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module ahb_uart_tx #(
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic         CLK,
   input  logic         RST,
   ahb_uart_tx_if.slave bus,
   output logic         tx,
   output logic         irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t state_q, state_d;

   logic          dp_vld_q, dp_vld_d;
   logic          dp_wr_q, dp_wr_d;
   logic [1:0]    dp_addr_q, dp_addr_d;
   logic [31:0]   hrdata_q, hrdata_d;
   logic [15:0]   div_q, div_d;
   logic          ovf_q, ovf_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [15:0]   baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shr_q, shr_d;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   logic        accept, wr_data, wr_div, rd_stat;
   logic        full, empty, push, pop, ovf_set;
   logic        tick, shift, busy, tx_c;
   logic [7:0]  head;
   logic [15:0] divm1;
   logic [31:0] status;

   logic unused_bits;
   assign unused_bits = ^{bus.hsize, bus.haddr[31:4],
                          bus.haddr[1:0], bus.hwdata[31:16]};

   assign bus.hready = 1'b1;
   assign bus.hresp  = 1'b0;
   assign bus.hrdata = hrdata_q;

   assign accept  = bus.hsel & bus.htrans[1] & bus.hready;
   assign wr_data = dp_vld_q & dp_wr_q & (dp_addr_q == 2'd0);
   assign wr_div  = dp_vld_q & dp_wr_q & (dp_addr_q == 2'd2);
   assign rd_stat = dp_vld_q & ~dp_wr_q & (dp_addr_q == 2'd1);

   assign full    = (cnt_q == CW'(FIFO_DEPTH));
   assign empty   = (cnt_q == '0);
   assign push    = wr_data & (~full | pop);
   assign ovf_set = wr_data & full & ~pop;
   assign head    = mem_q[rptr_q];

   assign tick  = (baud_q == 16'd0);
   assign divm1 = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
   assign busy  = (state_q != S_IDLE);
   assign irq   = empty & ~busy;
   assign tx    = tx_c;

   assign status = {23'd0, 5'(cnt_q), ovf_q, busy, empty, full};

   // Bus side: read data is captured in the address phase
   always_comb begin
      dp_vld_d  = accept;
      dp_wr_d   = bus.hwrite;
      dp_addr_d = bus.haddr[3:2];
      hrdata_d  = 32'd0;
      if (accept & ~bus.hwrite) begin
         unique case (bus.haddr[3:2])
            2'd1:    hrdata_d = status;
            2'd2:    hrdata_d = {16'd0, div_q};
            default: hrdata_d = 32'd0;
         endcase
      end
      div_d = wr_div ? bus.hwdata[15:0] : div_q;
      // Clear only what the read actually reported; a new overflow wins
      ovf_d = ovf_set | (ovf_q & ~(rd_stat & hrdata_q[3]));
   end

   always_comb begin
      wptr_d = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (!empty) state_d = S_START;
         S_START:  if (tick) state_d = S_DATA;
`ifdef UART_TX_PARITY_EN
         S_DATA:   if (tick && bit_q == 3'd7) state_d = S_PARITY;
         S_PARITY: if (tick) state_d = S_STOP;
`else
         S_DATA:   if (tick && bit_q == 3'd7) state_d = S_STOP;
`endif
         S_STOP:   if (tick) state_d = empty ? S_IDLE : S_START;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop   = 1'b0;
      shift = 1'b0;
      tx_c  = 1'b1;
      unique case (state_q)
         S_IDLE:   pop = ~empty;
         S_START:  tx_c = 1'b0;
         S_DATA: begin
            tx_c  = shr_q[0];
            shift = tick;
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_c = par_q;
`endif
         S_STOP:   pop = tick & ~empty;
         default:  tx_c = 1'b1;
      endcase
   end

   // Divisor is sampled only at bit boundaries
   always_comb begin
      baud_d = baud_q;
      if (pop || (busy && tick)) baud_d = divm1;
      else if (busy) baud_d = baud_q - 16'd1;
      shr_d = shr_q;
      bit_d = bit_q;
      if (pop) begin
         shr_d = head;
         bit_d = 3'd0;
      end else if (shift) begin
         shr_d = {1'b0, shr_q[7:1]};
         bit_d = bit_q + 3'd1;
      end
`ifdef UART_TX_PARITY_EN
      par_d = pop ? ^head : par_q;
`endif
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wptr_q] <= bus.hwdata[7:0];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dp_vld_q  <= 1'b0;
         dp_wr_q   <= 1'b0;
         dp_addr_q <= 2'd0;
         hrdata_q  <= 32'd0;
         div_q     <= 16'(CLK_DIV);
         ovf_q     <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         baud_q    <= 16'd0;
         bit_q     <= 3'd0;
         shr_q     <= 8'd0;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         dp_vld_q  <= dp_vld_d;
         dp_wr_q   <= dp_wr_d;
         dp_addr_q <= dp_addr_d;
         hrdata_q  <= hrdata_d;
         div_q     <= div_d;
         ovf_q     <= ovf_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shr_q     <= shr_d;
`ifdef UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_ahb_uart_tx.sv
// Directed bench for ahb_uart_tx: register table plus framed-serial sequences.
// Build with UART_TX_PARITY_EN defined to cover the 8E1 frame.
module tb_ahb_uart_tx;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic tx, irq;

   ahb_uart_tx_if bus ();

   ahb_uart_tx dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus),
      .tx  (tx),
      .irq (irq)
   );

   always #5 CLK = ~CLK;

`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   int pass_cnt = 0;
   int tot_cnt  = 0;
   int cyc      = 0;
   logic txlog  [16384];
   logic irqlog [16384];

   always @(posedge CLK) cyc <= cyc + 1;

   // tx/irq history indexed by the number of rising edges seen
   always @(negedge CLK) begin
      if (cyc < 16384) begin
         txlog[cyc]  <= tx;
         irqlog[cyc] <= irq;
      end
   end

   typedef struct {
      bit          wr;
      bit          sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tot_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic wr(input bit sel, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] r);
      bus.hsel   = sel;
      bus.htrans = 2'b10;
      bus.hwrite = 1'b1;
      bus.haddr  = a;
      @(negedge CLK);
      bus.hsel   = 1'b0;
      bus.htrans = 2'b00;
      bus.hwrite = 1'b0;
      bus.hwdata = d;
      r = bus.hrdata;
      @(negedge CLK);
   endtask

   task automatic wrx(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] r;
      wr(1'b1, a, d, r);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] r);
      bus.hsel   = 1'b1;
      bus.htrans = 2'b10;
      bus.hwrite = 1'b0;
      bus.haddr  = a;
      @(negedge CLK);
      bus.hsel   = 1'b0;
      bus.htrans = 2'b00;
      r = bus.hrdata;
      @(negedge CLK);
   endtask

   task automatic rdchk(input string nm, input logic [31:0] a,
                        input logic [31:0] exp);
      logic [31:0] r;
      rd(a, r);
      chk(nm, r, exp);
   endtask

   task automatic pulse_reset();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   function automatic logic [10:0] frame(input logic [7:0] b);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = b;
`ifdef UART_TX_PARITY_EN
      f[9]   = ^b;
`endif
      return f;
   endfunction

   task automatic check_frames(input string nm, input int ts, input int nb,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input int div);
      int bad;
      int d;
      logic [10:0] f;
      bad = 0;
      d = (div < 1) ? 1 : div;
      if (txlog[ts-1] !== 1'b1) bad++;
      for (int k = 0; k < nb; k++) begin
         f = frame((k == 0) ? b0 : b1);
         for (int i = 0; i < FB * d; i++)
            if (txlog[ts + k*FB*d + i] !== f[i/d]) bad++;
      end
      if (txlog[ts + nb*FB*d] !== 1'b1) bad++;
      chk(nm, bad, 0);
   endtask

   initial begin
      logic [31:0] r;
      int t0;
      int bad;

      bus.hsel   = 1'b0;
      bus.htrans = 2'b00;
      bus.hwrite = 1'b0;
      bus.haddr  = 32'd0;
      bus.hwdata = 32'd0;
      bus.hsize  = 3'b010;

      vt[0]  = '{1'b0, 1'b1, 32'h4, 32'h0,         32'h2};
      vt[1]  = '{1'b0, 1'b1, 32'h8, 32'h0,         32'd868};
      vt[2]  = '{1'b0, 1'b1, 32'h0, 32'h0,         32'h0};
      vt[3]  = '{1'b0, 1'b1, 32'hC, 32'h0,         32'h0};
      vt[4]  = '{1'b1, 1'b1, 32'h8, 32'hDEAD1234,  32'h0};
      vt[5]  = '{1'b0, 1'b1, 32'h8, 32'h0,         32'h1234};
      vt[6]  = '{1'b1, 1'b1, 32'hC, 32'hFFFFFFFF,  32'h0};
      vt[7]  = '{1'b0, 1'b1, 32'hC, 32'h0,         32'h0};
      vt[8]  = '{1'b1, 1'b0, 32'h8, 32'h000000AA,  32'h0};
      vt[9]  = '{1'b0, 1'b1, 32'h8, 32'h0,         32'h1234};
      vt[10] = '{1'b1, 1'b0, 32'h0, 32'h00000041,  32'h0};
      vt[11] = '{1'b1, 1'b1, 32'h8, 32'h4,         32'h0};
      vt[12] = '{1'b0, 1'b1, 32'h4, 32'h0,         32'h2};

      repeat (3) @(negedge CLK);
      chk("rst_tx", tx, 1);
      chk("rst_irq", irq, 1);
      chk("rst_hrdata", bus.hrdata, 0);
      chk("hready", bus.hready, 1);
      chk("hresp", bus.hresp, 0);
      RST = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < 13; i++) begin
         if (vt[i].wr) wr(vt[i].sel, vt[i].addr, vt[i].wdata, r);
         else          rd(vt[i].addr, r);
         chk($sformatf("vec%0d", i), r, vt[i].exp);
      end

      // 0x55 at DIV=4
      t0 = cyc;
      wrx(32'h0, 32'h55);
      repeat (8) @(negedge CLK);
      rdchk("st_busy", 32'h4, 32'h6);
      repeat (40) @(negedge CLK);
      check_frames("frame55", t0 + 3, 1, 8'h55, 8'h00, 4);
      bad = 0;
      for (int i = 0; i < FB * 4; i++)
         if (irqlog[t0 + 3 + i] !== 1'b0) bad++;
      chk("irq_frame", bad, 0);
      chk("irq_after", irqlog[t0 + 3 + FB*4], 1);
      rdchk("st_after", 32'h4, 32'h2);

      // DIV=0 behaves as one cycle per bit
      wrx(32'h8, 32'h0);
      rdchk("div0_rb", 32'h8, 32'h0);
      rdchk("rsvd_rb2", 32'hC, 32'h0);
      t0 = cyc;
      wrx(32'h0, 32'h01);
      repeat (FB + 6) @(negedge CLK);
      check_frames("frame01_div0", t0 + 3, 1, 8'h01, 8'h00, 1);

      // Back-to-back frames at DIV=2
      wrx(32'h8, 32'h2);
      t0 = cyc;
      wrx(32'h0, 32'hA5);
      wrx(32'h0, 32'h3C);
      repeat (2*FB*2 + 8) @(negedge CLK);
      check_frames("b2b", t0 + 3, 2, 8'hA5, 8'h3C, 2);

`ifdef UART_TX_PARITY_EN
      t0 = cyc;
      wrx(32'h0, 32'h07);
      wrx(32'h0, 32'h03);
      repeat (2*22 + 8) @(negedge CLK);
      check_frames("par_frames", t0 + 3, 2, 8'h07, 8'h03, 2);
      chk("par07", txlog[t0 + 3 + 18], 1);
      chk("par03", txlog[t0 + 3 + 22 + 18], 0);
`endif

      // Overflow with a slow shifter
      pulse_reset();
      wrx(32'h8, 32'd1000);
      for (int i = 0; i < 9; i++) wrx(32'h0, 32'h30 + i);
      rdchk("st_full", 32'h4, 32'h85);
      wrx(32'h0, 32'hEE);
      rdchk("st_ovf", 32'h4, 32'h8D);
      rdchk("st_clr", 32'h4, 32'h85);

      // Reset during data bit 3 of 0xFF
      pulse_reset();
      wrx(32'h8, 32'h4);
      t0 = cyc;
      wrx(32'h0, 32'hFF);
      repeat (18) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("rstff_tx", tx, 1);
      RST = 1'b0;
      @(negedge CLK);
      chk("rstff_irq", irq, 1);
      rdchk("rstff_st", 32'h4, 32'h2);
      rdchk("rstff_div", 32'h8, 32'd868);

      // Reset during data bit 3 of 0x00: tx must rise
      wrx(32'h8, 32'h4);
      t0 = cyc;
      wrx(32'h0, 32'h00);
      repeat (18) @(negedge CLK);
      chk("rst00_pre", tx, 0);
      RST = 1'b1;
      @(negedge CLK);
      chk("rst00_tx", tx, 1);
      RST = 1'b0;
      @(negedge CLK);
      rdchk("rst00_st", 32'h4, 32'h2);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
